// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_pkg : shared types and helpers for the elastic skid pipeline
// Revision : 1.0
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_reg_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_skid_reg_if : one valid/ready/data channel with master/slave views
// Revision : 1.0
// ---------------------------------------------------------------------------
interface pipe_skid_reg_if #(
  parameter int WIDTH = 8
) ();

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_skid_stage : one skid stage (main + skid register), registered ready
// Revision : 1.0
// ---------------------------------------------------------------------------
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             m_valid_q, m_valid_d;
  logic             s_ready_q, s_ready_d;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = s_valid & s_ready_q;
  assign out_fire = m_valid_q & m_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = s_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = s_data;
        end else if (in_fire) begin
          state_d = TWO;
          skid_d  = s_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush dominates: an accepted beat this cycle is discarded
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end
    m_valid_d = (state_d != EMPTY);
    s_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= EMPTY;
      main_q    <= RESET_VAL;
      skid_q    <= RESET_VAL;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = main_q;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_skid_reg : DEPTH chained skid stages with flush and occupancy count
// Revision : 1.0
// ---------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OCC_W     = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  pipe_skid_reg_if.slave   s_if,
  pipe_skid_reg_if.master  m_if,
  output logic [OCC_W-1:0] occupancy
);

  // Index i is the channel feeding stage i; index DEPTH is the output channel
  logic [DEPTH:0]   stage_valid;
  logic [DEPTH:0]   stage_ready;
  logic [WIDTH-1:0] stage_data [DEPTH+1];

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_fire;
  logic             out_fire;

  assign stage_valid[0]     = s_if.valid;
  assign stage_data[0]      = s_if.data;
  assign s_if.ready         = stage_ready[0];
  assign m_if.valid         = stage_valid[DEPTH];
  assign m_if.data          = stage_data[DEPTH];
  assign stage_ready[DEPTH] = m_if.ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_skid_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .s_valid (stage_valid[i]),
      .s_ready (stage_ready[i]),
      .s_data  (stage_data[i]),
      .m_valid (stage_valid[i+1]),
      .m_ready (stage_ready[i+1]),
      .m_data  (stage_data[i+1])
    );
  end

  assign in_fire  = stage_valid[0] & stage_ready[0];
  assign out_fire = stage_valid[DEPTH] & stage_ready[DEPTH];

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg : directed + random-stall bench for pipe_skid_reg (DEPTH=3)
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int         DEPTH = 3;
  localparam logic [7:0] RV    = 8'hA5;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [2:0] occ;

  int total_cnt;
  int bad_cnt;
  logic [7:0] sb[$];

  pipe_skid_reg_if #(.WIDTH(8)) up_if ();
  pipe_skid_reg_if #(.WIDTH(8)) dn_if ();

  pipe_skid_reg #(
    .WIDTH     (8),
    .DEPTH     (DEPTH),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .reset_n   (rst_n),
    .flush     (flush),
    .s_if      (up_if),
    .m_if      (dn_if),
    .occupancy (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: sample fires before the edge, update the scoreboard after it
  task automatic tick();
    logic       inf, outf, fl, stall;
    logic [7:0] id, od;
    inf   = up_if.valid && up_if.ready;
    outf  = dn_if.valid && dn_if.ready;
    stall = dn_if.valid && !dn_if.ready;
    fl    = flush;
    id    = up_if.data;
    od    = dn_if.data;
    @(posedge clk);
    #1;
    if (outf) begin
      if (sb.size() == 0) chk("spurious_out", 32'(outf), 32'd0);
      else chk("order", 32'(od), 32'(sb.pop_front()));
    end
    if (fl) sb.delete();
    else if (inf) sb.push_back(id);
    if (stall && !fl) begin
      chk("hold_valid", 32'(dn_if.valid), 32'd1);
      chk("hold_data", 32'(dn_if.data), 32'(od));
    end
    chk("occ", 32'(occ), 32'(sb.size()));
  endtask

  task automatic drain(input int bound);
    int n;
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(sb.size()), 32'd0);
    tick();
    chk("drain_in_ready", 32'(up_if.ready), 32'd1);
    chk("drain_out_valid", 32'(dn_if.valid), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ovalid"}, 32'(dn_if.valid), 32'd0);
    chk({tag, "_odata"}, 32'(dn_if.data), 32'(RV));
    chk({tag, "_occ"}, 32'(occ), 32'd0);
    chk({tag, "_iready"}, 32'(up_if.ready), 32'd1);
  endtask

  initial begin
    int acc;
    logic [7:0] nxt;
    logic f;
    total_cnt   = 0;
    bad_cnt     = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      up_if.valid = 1'($urandom);
      up_if.data  = 8'($urandom);
      dn_if.ready = 1'($urandom);
      flush       = 1'($urandom);
      #2;
      chk_reset_vals("rst");
    end
    up_if.valid = 1'b0;
    dn_if.ready = 1'b0;
    flush       = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Latency: beat accepted in cycle c shows up in cycle c+DEPTH
    up_if.valid = 1'b1;
    up_if.data  = 8'h11;
    dn_if.ready = 1'b1;
    tick();
    up_if.valid = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      chk("lat_early_valid", 32'(dn_if.valid), 32'd0);
      tick();
    end
    chk("lat_valid", 32'(dn_if.valid), 32'd1);
    chk("lat_data", 32'(dn_if.data), 32'h11);
    drain(10);

    // Streaming 0x00..0x3F at one beat per cycle
    dn_if.ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      up_if.valid = 1'b1;
      up_if.data  = 8'(k);
      chk("stream_in_ready", 32'(up_if.ready), 32'd1);
      tick();
      if (k >= DEPTH - 1) begin
        chk("stream_occ", 32'(occ), 32'(DEPTH));
        chk("stream_valid", 32'(dn_if.valid), 32'd1);
      end
    end
    drain(10);

    // Back-pressure fill: exactly 2*DEPTH beats absorbed
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    nxt = 8'h40;
    up_if.data = nxt;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      f = up_if.valid && up_if.ready;
      tick();
      if (f) begin
        acc++;
        nxt = nxt + 8'd1;
        up_if.data = nxt;
      end
    end
    chk("fill_count", 32'(acc), 32'(2 * DEPTH));
    chk("fill_in_ready", 32'(up_if.ready), 32'd0);
    chk("fill_occ", 32'(occ), 32'(2 * DEPTH));
    chk("fill_head", 32'(dn_if.data), 32'h40);
    drain(20);

    // Random stall traffic
    up_if.valid = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!(up_if.valid && !up_if.ready)) begin
        up_if.valid = 1'($urandom);
        up_if.data  = 8'($urandom);
      end
      dn_if.ready = 1'($urandom);
      tick();
      if (occ == 3'd0) chk("empty_no_valid", 32'(dn_if.valid), 32'd0);
      if (occ == 3'(2 * DEPTH)) chk("full_no_ready", 32'(up_if.ready), 32'd0);
    end
    drain(20);

    // Flush with 4 beats held plus in_fire and out_fire in the same cycle
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    nxt = 8'h50;
    up_if.data = nxt;
    acc = 0;
    for (int k = 0; k < 20 && acc < 4; k++) begin
      f = up_if.valid && up_if.ready;
      tick();
      if (f) begin
        acc++;
        nxt = nxt + 8'd1;
        up_if.data = nxt;
      end
    end
    chk("flush_setup", 32'(acc), 32'd4);
    up_if.data  = 8'hEE;
    dn_if.ready = 1'b1;
    flush       = 1'b1;
    chk("flush_pre_ovalid", 32'(dn_if.valid), 32'd1);
    chk("flush_pre_iready", 32'(up_if.ready), 32'd1);
    chk("flush_pre_head", 32'(dn_if.data), 32'h50);
    tick();
    flush       = 1'b0;
    up_if.valid = 1'b0;
    chk_reset_vals("flush");
    for (int k = 0; k < 6; k++) tick();

    // Async reset mid-stream while full
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 8'h70;
    for (int k = 0; k < 10; k++) tick();
    chk("arst_full_occ", 32'(occ), 32'(2 * DEPTH));
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    sb.delete();
    @(posedge clk);
    #1;
    up_if.valid = 1'b0;
    rst_n = 1'b1;
    dn_if.ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      up_if.valid = 1'b1;
      up_if.data  = 8'(8'h90 + k);
      tick();
    end
    drain(10);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
